prbs4_checker: RTL and testbench

PRBS4_CHECKER -- requirements
Module: prbs4_checker

---
 rtl/prbs4_checker.sv | 134 +++++++++++++
 tb/tb_prbs4_checker.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/prbs4_checker.sv
// Serial PRBS4 (x^4 + x^3 + 1) checker: searches for a non-zero seed, verifies
// it against incoming bits, then tracks lock and counts bit errors.
module prbs4_checker #(
   parameter int unsigned LOCK_CNT = 8,
   parameter int unsigned LOSS_CNT = 3,
   parameter int unsigned ERR_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din_valid,
   input  logic             din,
   input  logic             clr_err,
   output logic             locked,
   output logic             err,
   output logic [ERR_W-1:0] err_count,
   output logic [1:0]       sync_state
);

   typedef enum logic [1:0] {
      ST_SEARCH = 2'b00,
      ST_VERIFY = 2'b01,
      ST_LOCKED = 2'b10
   } state_t;

   localparam int unsigned MW = $clog2(LOCK_CNT + 1);
   localparam int unsigned LW = $clog2(LOSS_CNT + 1);

   state_t           state_q, state_d;
   logic [3:0]       s_q, s_d;
   logic [1:0]       load_q, load_d;
   logic [MW-1:0]    match_q, match_d;
   logic [LW-1:0]    loss_q, loss_d;
   logic             err_q, err_d;
   logic [ERR_W-1:0] cnt_q, cnt_d;
   logic             inc;
   logic             pred;
   logic [3:0]       s_din;

   assign pred  = s_q[3] ^ s_q[2];
   assign s_din = {s_q[2:0], din};

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      load_d  = load_q;
      match_d = match_q;
      loss_d  = loss_q;
      err_d   = 1'b0;
      inc     = 1'b0;
      if (din_valid) begin
         unique case (state_q)
            ST_SEARCH: begin
               s_d = s_din;
               if (load_q == 2'd3) begin
                  load_d  = '0;
                  match_d = '0;
                  if (s_din != 4'b0000) state_d = ST_VERIFY;
               end else begin
                  load_d = load_q + 2'd1;
               end
            end
            ST_VERIFY: begin
               if (din == pred) begin
                  s_d = s_din;
                  if (match_q == MW'(LOCK_CNT - 1)) begin
                     state_d = ST_LOCKED;
                     match_d = '0;
                     loss_d  = '0;
                  end else begin
                     match_d = match_q + MW'(1);
                  end
               end else begin
                  state_d = ST_SEARCH;
                  load_d  = '0;
                  match_d = '0;
               end
            end
            ST_LOCKED: begin
               // Reference free-runs on its own prediction so line errors never corrupt it
               s_d = {s_q[2:0], pred};
               if (din != pred) begin
                  err_d = 1'b1;
                  inc   = 1'b1;
                  if (loss_q == LW'(LOSS_CNT - 1)) begin
                     state_d = ST_SEARCH;
                     load_d  = '0;
                     match_d = '0;
                     loss_d  = '0;
                  end else begin
                     loss_d = loss_q + LW'(1);
                  end
               end else begin
                  loss_d = '0;
               end
            end
            default: begin
               state_d = ST_SEARCH;
               load_d  = '0;
               match_d = '0;
               loss_d  = '0;
            end
         endcase
      end
      cnt_d = cnt_q;
      if (clr_err)                  cnt_d = '0;
      else if (inc && cnt_q != '1)  cnt_d = cnt_q + ERR_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_SEARCH;
         s_q     <= '0;
         load_q  <= '0;
         match_q <= '0;
         loss_q  <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         load_q  <= load_d;
         match_q <= match_d;
         loss_q  <= loss_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign locked     = (state_q == ST_LOCKED);
   assign sync_state = state_q;
   assign err        = err_q;
   assign err_count  = cnt_q;

endmodule

// File: tb/tb_prbs4_checker.sv
// Randomised scoreboard bench for prbs4_checker against a queue-based
// behavioural model of the search / verify / lock rules.
module tb_prbs4_checker;

   localparam int unsigned ERR_W = 8;
   localparam int SAT = (1 << ERR_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             din_valid = 1'b0;
   logic             din = 1'b0;
   logic             clr_err = 1'b0;
   logic             locked;
   logic             err;
   logic [ERR_W-1:0] err_count;
   logic [1:0]       sync_state;

   prbs4_checker #(.LOCK_CNT(8), .LOSS_CNT(3), .ERR_W(ERR_W)) dut (
      .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .clr_err(clr_err),
      .locked(locked), .err(err), .err_count(err_count), .sync_state(sync_state)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [11:0] exp_q[$];

   // PRBS source: one period of the sequence seeded 0,0,0,1
   int prbs[15];
   int pos = 0;

   function automatic logic next_bit();
      logic b;
      b = prbs[pos % 15][0];
      pos++;
      return b;
   endfunction

   // Reference model: mode 0 search, 1 verify, 2 locked; hist holds the last four reference bits
   int m_mode = 0, m_ld = 0, m_match = 0, m_loss = 0, m_cnt = 0, m_err = 0;
   int hist[$];

   task automatic model(input logic r, input logic v, input logic d, input logic c);
      int pr;
      int inc;
      inc = 0;
      if (r) begin
         m_mode = 0; m_ld = 0; m_match = 0; m_loss = 0; m_cnt = 0; m_err = 0;
         hist.delete();
         return;
      end
      m_err = 0;
      if (v) begin
         if (m_mode == 0) begin
            hist.push_back(int'(d));
            if (hist.size() > 4) void'(hist.pop_front());
            m_ld++;
            if (m_ld == 4) begin
               m_ld = 0;
               m_match = 0;
               if (hist[0] + hist[1] + hist[2] + hist[3] != 0) m_mode = 1;
            end
         end else if (m_mode == 1) begin
            pr = hist[0] ^ hist[1];
            if (int'(d) == pr) begin
               hist.push_back(pr);
               void'(hist.pop_front());
               m_match++;
               if (m_match == 8) begin m_mode = 2; m_match = 0; m_loss = 0; end
            end else begin
               m_mode = 0; m_ld = 0; m_match = 0;
            end
         end else begin
            pr = hist[0] ^ hist[1];
            hist.push_back(pr);
            void'(hist.pop_front());
            if (int'(d) != pr) begin
               m_err = 1;
               inc = 1;
               m_loss++;
               if (m_loss == 3) begin m_mode = 0; m_ld = 0; m_loss = 0; end
            end else begin
               m_loss = 0;
            end
         end
      end
      if (c) m_cnt = 0;
      else if (inc == 1 && m_cnt < SAT) m_cnt++;
   endtask

   task automatic step(input logic r, input logic v, input logic d, input logic c);
      logic [1:0] st;
      @(negedge clk);
      rst = r; din_valid = v; din = d; clr_err = c;
      model(r, v, d, c);
      st = (m_mode == 2) ? 2'b10 : (m_mode == 1) ? 2'b01 : 2'b00;
      exp_q.push_back({(m_mode == 2), (m_err == 1), ERR_W'(m_cnt), st});
   endtask

   task automatic check1(input string name, input logic act, input logic expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0b expected %0b at %0t", name, act, expv, $time);
      end
   endtask

   // Monitor: every cycle with a pending expectation is compared against the DUT
   initial begin
      logic [11:0] e, a;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {locked, err, err_count, sync_state};
            checks++;
            if (a !== e) begin
               errors++;
               $display("FAIL outputs: got locked=%0b err=%0b cnt=%0d st=%02b expected locked=%0b err=%0b cnt=%0d st=%02b at %0t",
                        a[11], a[10], a[9:2], a[1:0], e[11], e[10], e[9:2], e[1:0], $time);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int nv;
      int cyc;
      logic done;
      logic v;
      prbs[0] = 0; prbs[1] = 0; prbs[2] = 0; prbs[3] = 1;
      for (int n = 4; n < 15; n++) prbs[n] = prbs[n-4] ^ prbs[n-3];

      // Reset, then clean stream: lock exactly after the 12th valid bit
      repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i <= 12; i++) begin
         step(1'b0, 1'b1, next_bit(), 1'b0);
         @(posedge clk); #1;
         if (i == 11) check1("pre_lock_11", locked, 1'b0);
         if (i == 12) check1("lock_12", locked, 1'b1);
      end
      for (int i = 0; i < 188; i++) step(1'b0, 1'b1, next_bit(), 1'b0);

      // Single inverted bit, then clean data
      step(1'b0, 1'b1, ~next_bit(), 1'b0);
      for (int i = 0; i < 30; i++) step(1'b0, 1'b1, next_bit(), 1'b0);

      // Three consecutive inversions drop lock; clean data relocks
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, ~next_bit(), 1'b0);
      for (int i = 0; i < 40; i++) step(1'b0, 1'b1, next_bit(), 1'b0);

      // All-zero stream never leaves SEARCH
      step(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 1'b0, 1'b0);

      // Alternate inversions saturate err_count; clear wins over a simultaneous error
      step(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) step(1'b0, 1'b1, next_bit(), 1'b0);
      for (int i = 0; i < 600; i++) begin
         if (i % 2 == 0) step(1'b0, 1'b1, ~next_bit(), 1'b0);
         else            step(1'b0, 1'b1, next_bit(), 1'b0);
      end
      step(1'b0, 1'b1, ~next_bit(), 1'b1);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, next_bit(), 1'b0);

      // Random valid gaps: lock after exactly 12 valid bits, then reset while locked
      step(1'b1, 1'b0, 1'b0, 1'b0);
      nv = 0; cyc = 0; done = 1'b0;
      while (!done && cyc < 400) begin
         v = 1'($urandom_range(0, 1));
         step(1'b0, v, v ? next_bit() : 1'($urandom_range(0, 1)), 1'b0);
         if (v) nv++;
         @(posedge clk); #1;
         cyc++;
         if (locked === 1'b1) done = 1'b1;
      end
      check1("gap_lock_seen", done, 1'b1);
      check1("gap_lock_at_12", (nv == 12), 1'b1);
      for (int i = 0; i < 30; i++) begin
         v = 1'($urandom_range(0, 1));
         step(1'b0, v, v ? next_bit() : 1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
      end
      step(1'b1, 1'b1, next_bit(), 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);

      cyc = 0;
      while (exp_q.size() > 0 && cyc < 10) begin
         @(posedge clk); #2;
         cyc++;
      end
      check1("scoreboard_drained", (exp_q.size() == 0), 1'b1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
